isp_stat_ae: RTL and testbench

//  Per-frame luminance statistics collector feeding the auto-exposure controller.

---
 rtl/isp_stat_ae_if.sv | 32 +++
 rtl/isp_stat_ae.sv | 148 ++++++++++++++
 tb/tb_isp_stat_ae.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/isp_stat_ae_if.sv
// Signal bundle between the pixel-stream tap / AE controller side and the
// statistics collector.
interface isp_stat_ae_if #(
    parameter int BITS = 8,
    parameter int CW   = 16
);
    // Stream semantics: in_href qualifies in_raw on each cycle. There is no ready
    // signal and no backpressure, because the collector only observes the stream.
    // in_vsync high marks blanking. stat_done qualifies pix_cnt/sum for one cycle.
    logic            stat_en;
    logic [CW-1:0]   win_x;
    logic [CW-1:0]   win_y;
    logic [CW-1:0]   win_w;
    logic [CW-1:0]   win_h;
    logic            in_vsync;
    logic            in_href;
    logic [BITS-1:0] in_raw;
    logic [31:0]     pix_cnt;
    logic [31:0]     sum;
    logic            stat_done;
    logic [1:0]      dbg_state;

    modport master (
        output stat_en, win_x, win_y, win_w, win_h, in_vsync, in_href, in_raw,
        input  pix_cnt, sum, stat_done, dbg_state
    );

    modport slave (
        input  stat_en, win_x, win_y, win_w, win_h, in_vsync, in_href, in_raw,
        output pix_cnt, sum, stat_done, dbg_state
    );
endinterface

// File: rtl/isp_stat_ae.sv
// Per-frame windowed luminance statistics (pixel count and sum) for auto-exposure.
// Passively taps the pixel stream and publishes the results once per frame with stat_done.
module isp_stat_ae #(
    parameter int BITS = 8,
    parameter int CW   = 16
) (
    input logic          pclk,
    input logic          rst,
    isp_stat_ae_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        PUBLISH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          prev_vs_q, prev_vs_d;
    logic          prev_href_q, prev_href_d;
    logic          frame_valid_q, frame_valid_d;
    logic [CW-1:0] sx_q, sx_d, sy_q, sy_d, sw_q, sw_d, sh_q, sh_d;
    logic [CW-1:0] col_q, col_d, line_q, line_d;
    logic [31:0]   acc_cnt_q, acc_cnt_d, acc_sum_q, acc_sum_d;
    logic [31:0]   pix_cnt_q, pix_cnt_d, sum_q, sum_d;

    logic          fs, fe, href_act, href_fall, in_win, qualify;
    logic [CW:0]   x_end, y_end;
    logic [32:0]   sum_ext;

    assign fs        = prev_vs_q & ~bus.in_vsync;
    assign fe        = ~prev_vs_q & bus.in_vsync;
    // href during blanking is not part of any line
    assign href_act  = bus.in_href & ~bus.in_vsync;
    assign href_fall = prev_href_q & ~href_act;

    // window ends carry one extra bit so x+w never wraps back into range
    assign x_end   = {1'b0, sx_q} + {1'b0, sw_q};
    assign y_end   = {1'b0, sy_q} + {1'b0, sh_q};
    assign in_win  = (col_q >= sx_q) && ({1'b0, col_q} < x_end) &&
                     (line_q >= sy_q) && ({1'b0, line_q} < y_end);
    assign qualify = href_act & frame_valid_q & in_win;
    assign sum_ext = {1'b0, acc_sum_q} + {{(33 - BITS){1'b0}}, bus.in_raw};

    always_comb begin
        prev_vs_d     = bus.in_vsync;
        prev_href_d   = href_act;
        frame_valid_d = frame_valid_q;
        sx_d          = sx_q;
        sy_d          = sy_q;
        sw_d          = sw_q;
        sh_d          = sh_q;
        col_d         = col_q;
        line_d        = line_q;
        acc_cnt_d     = acc_cnt_q;
        acc_sum_d     = acc_sum_q;
        if (fs) begin
            sx_d          = bus.win_x;
            sy_d          = bus.win_y;
            sw_d          = bus.win_w;
            sh_d          = bus.win_h;
            col_d         = '0;
            line_d        = '0;
            acc_cnt_d     = '0;
            acc_sum_d     = '0;
            frame_valid_d = bus.stat_en;
        end else begin
            if (href_act) begin
                col_d = (&col_q) ? col_q : col_q + 1'b1;
            end else if (href_fall) begin
                col_d  = '0;
                line_d = (&line_q) ? line_q : line_q + 1'b1;
            end
            if (qualify) begin
                acc_cnt_d = (&acc_cnt_q) ? acc_cnt_q : acc_cnt_q + 1'b1;
                acc_sum_d = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
            end
            if (fe) begin
                frame_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        sum_d     = sum_q;
        case (state_q)
            IDLE: begin
                if (fs) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (fe) begin
                    if (frame_valid_q) begin
                        state_d   = PUBLISH;
                        pix_cnt_d = acc_cnt_q;
                        sum_d     = acc_sum_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            PUBLISH: begin
                // a single blanking cycle allows the next frame to start right away
                state_d = fs ? ACTIVE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q       <= IDLE;
            prev_vs_q     <= 1'b0;
            prev_href_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            sx_q          <= '0;
            sy_q          <= '0;
            sw_q          <= '0;
            sh_q          <= '0;
            col_q         <= '0;
            line_q        <= '0;
            acc_cnt_q     <= '0;
            acc_sum_q     <= '0;
            pix_cnt_q     <= '0;
            sum_q         <= '0;
        end else begin
            state_q       <= state_d;
            prev_vs_q     <= prev_vs_d;
            prev_href_q   <= prev_href_d;
            frame_valid_q <= frame_valid_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            sw_q          <= sw_d;
            sh_q          <= sh_d;
            col_q         <= col_d;
            line_q        <= line_d;
            acc_cnt_q     <= acc_cnt_d;
            acc_sum_q     <= acc_sum_d;
            pix_cnt_q     <= pix_cnt_d;
            sum_q         <= sum_d;
        end
    end

    assign bus.pix_cnt   = pix_cnt_q;
    assign bus.sum       = sum_q;
    assign bus.stat_done = (state_q == PUBLISH);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_isp_stat_ae.sv
// Bench for isp_stat_ae: frames are built in the bench, and a per-frame window model
// predicts the published count, sum and pulse cycle.
module tb_isp_stat_ae;
    localparam int BITS = 8;
    localparam int CW   = 16;

    logic pclk = 1'b0;
    logic rst;
    always #5 pclk = ~pclk;

    isp_stat_ae_if #(.BITS(BITS), .CW(CW)) bus();
    isp_stat_ae #(.BITS(BITS), .CW(CW)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          chk_en = 1'b0;
    int          due_q[$];
    logic [31:0] exp_cnt_q[$];
    logic [31:0] exp_sum_q[$];
    logic [31:0] model_cnt = '0;
    logic [31:0] model_sum = '0;

    // clock/reset helpers
    task automatic tick();
        @(negedge pclk);
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // every-cycle compare against the model's published values and pulse schedule
    always @(posedge pclk) begin
        bit exp_done;
        #1;
        cyc++;
        if (chk_en) begin
            exp_done = (due_q.size() > 0) && (due_q[0] == cyc);
            checks++;
            if (bus.stat_done !== exp_done) begin
                errors++;
                $display("FAIL stat_done cyc=%0d: got %b expected %b", cyc, bus.stat_done, exp_done);
            end
            if (exp_done) begin
                void'(due_q.pop_front());
                model_cnt = exp_cnt_q.pop_front();
                model_sum = exp_sum_q.pop_front();
            end else if (due_q.size() > 0 && due_q[0] < cyc) begin
                void'(due_q.pop_front());
                void'(exp_cnt_q.pop_front());
                void'(exp_sum_q.pop_front());
            end
            checks++;
            if (bus.pix_cnt !== model_cnt) begin
                errors++;
                $display("FAIL pix_cnt cyc=%0d: got %0d expected %0d", cyc, bus.pix_cnt, model_cnt);
            end
            checks++;
            if (bus.sum !== model_sum) begin
                errors++;
                $display("FAIL sum cyc=%0d: got %0h expected %0h", cyc, bus.sum, model_sum);
            end
        end
    end

    function automatic logic [7:0] pixval(input int mode, input int c);
        case (mode)
            0:       return 8'd16;
            1:       return 8'(c);
            3:       return 8'd255;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // driver: one full frame, blanking first; called and returns just after a negedge
    task automatic drive_frame(input int w, input int h, input int mode, input bit en,
                               input int wx, input int wy, input int ww, input int wh,
                               input int new_ww, input bit do_force, input int rst_line);
        longint      e_cnt;
        longint      e_sum;
        bit          fv;
        int          sx, sy, sw, sh;
        logic [7:0]  px;
        bus.win_x   = 16'(wx);
        bus.win_y   = 16'(wy);
        bus.win_w   = 16'(ww);
        bus.win_h   = 16'(wh);
        bus.stat_en = en;
        bus.in_vsync = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_href = 1'($urandom_range(0, 1));
            bus.in_raw  = 8'($urandom_range(0, 255));
            tick();
        end
        bus.in_vsync = 1'b0;
        bus.in_href  = 1'b0;
        sx = wx; sy = wy; sw = ww; sh = wh;
        fv = en;
        tick();
        bus.stat_en = 1'($urandom_range(0, 1));
        if (new_ww >= 0) bus.win_w = 16'(new_ww);
        if (do_force) force dut.acc_sum_q = 32'hFFFF_FF00;
        tick();
        if (do_force) release dut.acc_sum_q;
        tick();
        e_cnt = 0;
        e_sum = do_force ? 64'h0000_0000_FFFF_FF00 : 0;
        for (int l = 0; l < h; l++) begin
            if (l == rst_line) begin
                rst = 1'b1;
                bus.in_href = 1'b0;
                fv = 1'b0;
                model_cnt = '0;
                model_sum = '0;
                due_q.delete();
                exp_cnt_q.delete();
                exp_sum_q.delete();
                tick();
                tick();
                rst = 1'b0;
            end
            for (int c = 0; c < w; c++) begin
                px = pixval(mode, c);
                bus.in_href = 1'b1;
                bus.in_raw  = px;
                if (fv && c >= sx && c < sx + sw && l >= sy && l < sy + sh) begin
                    e_cnt++;
                    e_sum += px;
                end
                tick();
            end
            bus.in_href = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        // frame end; a pixel offered in this cycle must be excluded
        bus.in_vsync = 1'b1;
        bus.in_href  = 1'($urandom_range(0, 1));
        bus.in_raw   = 8'($urandom_range(0, 255));
        if (fv) begin
            due_q.push_back(cyc + 1);
            exp_cnt_q.push_back(32'(e_cnt));
            exp_sum_q.push_back(e_sum > 64'h0000_0000_FFFF_FFFF ? 32'hFFFF_FFFF : 32'(e_sum));
        end
        tick();
        bus.in_href = 1'b0;
        tick();
    endtask

    initial begin
        int w, h;
        rst          = 1'b1;
        bus.stat_en  = 1'b0;
        bus.win_x    = '0;
        bus.win_y    = '0;
        bus.win_w    = '0;
        bus.win_h    = '0;
        bus.in_vsync = 1'b1;
        bus.in_href  = 1'b0;
        bus.in_raw   = '0;
        tick();
        tick();
        tick();
        check_lit("reset_pix_cnt", bus.pix_cnt, 32'd0);
        check_lit("reset_sum", bus.sum, 32'd0);
        check_lit("reset_stat_done", 32'(bus.stat_done), 32'd0);
        check_lit("reset_state", 32'(bus.dbg_state), 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // full window, flat 16
        drive_frame(8, 4, 0, 1'b1, 0, 0, 8, 4, -1, 1'b0, -1);
        check_lit("t1_cnt", bus.pix_cnt, 32'd32);
        check_lit("t1_sum", bus.sum, 32'd512);

        // column ramp, inner window
        drive_frame(8, 4, 1, 1'b1, 2, 1, 4, 2, -1, 1'b0, -1);
        check_lit("t2_cnt", bus.pix_cnt, 32'd8);
        check_lit("t2_sum", bus.sum, 32'd28);

        // width changed mid-frame takes effect only on the next frame
        drive_frame(8, 4, 0, 1'b1, 0, 0, 4, 4, 8, 1'b0, -1);
        check_lit("t3a_cnt", bus.pix_cnt, 32'd16);
        check_lit("t3a_sum", bus.sum, 32'd256);
        drive_frame(8, 4, 0, 1'b1, 0, 0, 8, 4, -1, 1'b0, -1);
        check_lit("t3b_cnt", bus.pix_cnt, 32'd32);
        check_lit("t3b_sum", bus.sum, 32'd512);

        // reset mid-frame drops that frame; next full frame publishes
        drive_frame(8, 4, 0, 1'b1, 0, 0, 8, 4, -1, 1'b0, 2);
        check_lit("t4a_cnt", bus.pix_cnt, 32'd0);
        drive_frame(8, 4, 0, 1'b1, 0, 0, 8, 4, -1, 1'b0, -1);
        check_lit("t4b_cnt", bus.pix_cnt, 32'd32);
        check_lit("t4b_sum", bus.sum, 32'd512);

        // disabled frame holds outputs; zero-width window publishes zeros
        drive_frame(8, 4, 2, 1'b0, 0, 0, 8, 4, -1, 1'b0, -1);
        check_lit("t5a_cnt", bus.pix_cnt, 32'd32);
        check_lit("t5a_sum", bus.sum, 32'd512);
        drive_frame(8, 4, 0, 1'b1, 0, 0, 0, 4, -1, 1'b0, -1);
        check_lit("t5b_cnt", bus.pix_cnt, 32'd0);
        check_lit("t5b_sum", bus.sum, 32'd0);

        // sum saturation
        drive_frame(4, 2, 3, 1'b1, 0, 0, 2, 1, -1, 1'b1, -1);
        check_lit("t6_cnt", bus.pix_cnt, 32'd2);
        check_lit("t6_sum", bus.sum, 32'hFFFF_FFFF);

        // randomized frames and windows
        for (int n = 0; n < 24; n++) begin
            w = $urandom_range(1, 12);
            h = $urandom_range(1, 8);
            drive_frame(w, h, $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
                        $urandom_range(0, 10), $urandom_range(0, 6),
                        $urandom_range(0, 12), $urandom_range(0, 8),
                        -1, 1'b0, -1);
        end

        for (int i = 0; i < 10 && due_q.size() > 0; i++) tick();
        checks++;
        if (due_q.size() != 0) begin
            errors++;
            $display("FAIL pending_publish: got %0d outstanding expected 0", due_q.size());
        end
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
